// File: rtl/pow_pkg.sv
// ---------------------------------------------------------------------------
// pow_pkg
// Shared definitions for the sequential power unit:
//   state_e     - control FSM state encoding (ST_IDLE, ST_CALC)
//   MODE_SHIFT  - MODE value selecting the single-cycle 2**EXP shift path
//   MODE_GEN    - MODE value selecting general BASE**EXP square-and-multiply
// ---------------------------------------------------------------------------
package pow_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_GEN   = 1'b1;

endpackage : pow_pkg

// File: rtl/pow_mul.sv
// ---------------------------------------------------------------------------
// pow_mul
// Combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier. The full
// product is kept so the caller can detect overflow from the high half.
// Ports:
//   i_a  in  WIDTH    multiplicand
//   i_b  in  WIDTH    multiplier
//   o_p  out 2*WIDTH  full product i_a * i_b
// ---------------------------------------------------------------------------
module pow_mul #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_p
);

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;

    // Zero-extend both operands so the multiply is evaluated at full product width.
    always_comb begin
        w_a_ext = {{WIDTH{1'b0}}, i_a};
        w_b_ext = {{WIDTH{1'b0}}, i_b};
        o_p     = w_a_ext * w_b_ext;
    end

endmodule : pow_mul

// File: rtl/pow_seq.sv
// ---------------------------------------------------------------------------
// pow_seq
// Sequential integer power unit with a START/BUSY/DONE handshake.
//   MODE 0: 2**EXP in one cycle via a shift.
//   MODE 1: BASE**EXP via LSB-first square-and-multiply, one exponent bit
//           per cycle. Result is mod 2**WIDTH; OVF flags a true result that
//           does not fit in WIDTH bits.
// Ports:
//   i_clk    in   1       clock, rising edge
//   i_rst    in   1       asynchronous active-high reset
//   i_start  in   1       request, sampled only while not busy
//   i_mode   in   1       0 = 2**EXP, 1 = BASE**EXP
//   i_base   in   WIDTH   base operand (MODE 1), latched with START
//   i_exp    in   EXP_W   exponent, latched with START
//   o_busy   out  1       high while calculating
//   o_done   out  1       one-cycle pulse when o_out/o_ovf update
//   o_out    out  WIDTH   result, held until the next DONE
//   o_ovf    out  1       overflow flag, held with o_out
// ---------------------------------------------------------------------------
module pow_seq
    import pow_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int EXP_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_base,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_out,
    output logic             o_ovf
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [EXP_W-1:0]   r_e;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_ovf;

    logic [2*WIDTH-1:0] w_mul_p;
    logic [2*WIDTH-1:0] w_sq_p;
    logic [EXP_W-1:0]   w_e_next;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_ovf_next;
    logic               w_exp_big;
    logic [WIDTH-1:0]   w_shift_out;

    pow_mul #(.WIDTH(WIDTH)) u_mul_acc (
        .i_a (r_acc),
        .i_b (r_b),
        .o_p (w_mul_p)
    );

    pow_mul #(.WIDTH(WIDTH)) u_mul_sq (
        .i_a (r_b),
        .i_b (r_b),
        .o_p (w_sq_p)
    );

    // MODE 0 shift path: exponents of WIDTH or more shift the one out entirely.
    always_comb begin
        w_exp_big = (32'(i_exp) >= 32'(WIDTH));
        if (w_exp_big) begin
            w_shift_out = {WIDTH{1'b0}};
        end else begin
            w_shift_out = {{(WIDTH-1){1'b0}}, 1'b1} << i_exp;
        end
    end

    // Next-step values for one square-and-multiply iteration.
    always_comb begin
        w_e_next = {1'b0, r_e[EXP_W-1:1]};
        if (r_e[0]) begin
            w_acc_next = w_mul_p[WIDTH-1:0];
        end else begin
            w_acc_next = r_acc;
        end
        // The square only matters if another exponent bit will consume it.
        w_ovf_next = r_ovf
                   | (r_e[0] & (|w_mul_p[2*WIDTH-1:WIDTH]))
                   | ((|w_sq_p[2*WIDTH-1:WIDTH]) & (w_e_next != {EXP_W{1'b0}}));
    end

    // Control FSM with operand, accumulator and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_e       <= {EXP_W{1'b0}};
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_out     <= {WIDTH{1'b0}};
            r_out_ovf <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        case (i_mode)
                            MODE_SHIFT: begin
                                r_out     <= w_shift_out;
                                r_out_ovf <= w_exp_big;
                                r_done    <= 1'b1;
                            end
                            MODE_GEN: begin
                                if (i_exp == {EXP_W{1'b0}}) begin
                                    // Anything to the zero, including 0**0, is 1.
                                    r_out     <= {{(WIDTH-1){1'b0}}, 1'b1};
                                    r_out_ovf <= 1'b0;
                                    r_done    <= 1'b1;
                                end else begin
                                    r_acc   <= {{(WIDTH-1){1'b0}}, 1'b1};
                                    r_b     <= i_base;
                                    r_e     <= i_exp;
                                    r_ovf   <= 1'b0;
                                    r_busy  <= 1'b1;
                                    r_state <= ST_CALC;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_b   <= w_sq_p[WIDTH-1:0];
                    r_e   <= w_e_next;
                    r_ovf <= w_ovf_next;
                    if (w_e_next == {EXP_W{1'b0}}) begin
                        r_out     <= w_acc_next;
                        r_out_ovf <= w_ovf_next;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_out  = r_out;
    assign o_ovf  = r_out_ovf;

endmodule : pow_seq

// File: tb/tb_pow_seq.sv
// ---------------------------------------------------------------------------
// tb_pow_seq
// Directed self-checking bench for pow_seq (WIDTH=16, EXP_W=7). Expected
// results are hand-computed constants; inputs change and outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pow_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_mode;
    logic [15:0] i_base;
    logic [6:0]  i_exp;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_out;
    logic        o_ovf;

    int n_checks;
    int n_errors;

    pow_seq #(.WIDTH(16), .EXP_W(7)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_base  (i_base),
        .i_exp   (i_exp),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_out   (o_out),
        .o_ovf   (o_ovf)
    );

    // Free-running clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op, scramble the inputs after acceptance, wait for DONE
    // (bounded) and check result, overflow, busy length and single pulse.
    task automatic run_op(input string tag, input logic mode, input logic [15:0] base,
                          input logic [6:0] e, input logic [15:0] exp_out,
                          input logic exp_ovf, input int exp_busy);
        int busy_cnt;
        int cyc;
        i_start = 1'b1;
        i_mode  = mode;
        i_base  = base;
        i_exp   = e;
        step();
        i_start = 1'b0;
        i_mode  = ~mode;
        i_base  = 16'hFFFF;
        i_exp   = 7'h7F;
        busy_cnt = 0;
        cyc      = 0;
        while (!o_done && cyc < 20) begin
            if (o_busy) busy_cnt++;
            step();
            cyc++;
        end
        chk({tag, " done"}, {31'd0, o_done}, 32'd1);
        chk({tag, " out"}, {16'd0, o_out}, {16'd0, exp_out});
        chk({tag, " ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, " busy_at_done"}, {31'd0, o_busy}, 32'd0);
        step();
        chk({tag, " done_single"}, {31'd0, o_done}, 32'd0);
        chk({tag, " out_held"}, {16'd0, o_out}, {16'd0, exp_out});
    endtask

    initial begin
        int busy_cnt;
        int cyc;
        n_checks = 0;
        n_errors = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_mode  = 1'b0;
        i_base  = 16'd0;
        i_exp   = 7'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset busy", {31'd0, o_busy}, 32'd0);
        chk("reset done", {31'd0, o_done}, 32'd0);
        chk("reset out", {16'd0, o_out}, 32'd0);
        chk("reset ovf", {31'd0, o_ovf}, 32'd0);
        i_rst = 1'b0;
        step();

        // MODE 0 shift path
        run_op("m0_e5",   1'b0, 16'd0, 7'd5,   16'd32,    1'b0, 0);
        run_op("m0_e16",  1'b0, 16'd0, 7'd16,  16'd0,     1'b1, 0);
        run_op("m0_e15",  1'b0, 16'd0, 7'd15,  16'd32768, 1'b0, 0);
        run_op("m0_e0",   1'b0, 16'd0, 7'd0,   16'd1,     1'b0, 0);
        run_op("m0_e127", 1'b0, 16'd0, 7'd127, 16'd0,     1'b1, 0);

        // MODE 1 square-and-multiply; busy cycles = msb_index(EXP)+1
        run_op("m1_3^5",    1'b1, 16'd3,   7'd5,   16'd243,   1'b0, 3);
        run_op("m1_0^0",    1'b1, 16'd0,   7'd0,   16'd1,     1'b0, 0);
        run_op("m1_2^16",   1'b1, 16'd2,   7'd16,  16'd0,     1'b1, 5);
        run_op("m1_256^1",  1'b1, 16'd256, 7'd1,   16'd256,   1'b0, 1);
        // 255**3 = 16581375 = 0xFD02FF; low 16 bits 0x02FF
        run_op("m1_255^3",  1'b1, 16'd255, 7'd3,   16'h02FF,  1'b1, 2);
        // 3**10 = 59049 fits; final unused square overflows but is ignored
        run_op("m1_3^10",   1'b1, 16'd3,   7'd10,  16'd59049, 1'b0, 4);
        run_op("m1_2^15",   1'b1, 16'd2,   7'd15,  16'd32768, 1'b0, 4);
        run_op("m1_1^127",  1'b1, 16'd1,   7'd127, 16'd1,     1'b0, 7);
        run_op("m1_0^5",    1'b1, 16'd0,   7'd5,   16'd0,     1'b0, 3);

        // START held high through 7**100: only the first op runs, then a
        // MODE 0 request presented in the DONE cycle is accepted back-to-back.
        // 7**100 mod 2**16 = 6753.
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_base  = 16'd7;
        i_exp   = 7'd100;
        step();
        i_mode  = 1'b0;
        i_base  = 16'd5;
        i_exp   = 7'd3;
        busy_cnt = 0;
        cyc      = 0;
        while (!o_done && cyc < 20) begin
            if (o_busy) busy_cnt++;
            step();
            cyc++;
        end
        chk("m1_7^100 done", {31'd0, o_done}, 32'd1);
        chk("m1_7^100 out", {16'd0, o_out}, 32'd6753);
        chk("m1_7^100 ovf", {31'd0, o_ovf}, 32'd1);
        chk("m1_7^100 busy_cycles", busy_cnt, 32'd7);
        step();
        i_start = 1'b0;
        chk("b2b done", {31'd0, o_done}, 32'd1);
        chk("b2b out", {16'd0, o_out}, 32'd8);
        chk("b2b ovf", {31'd0, o_ovf}, 32'd0);
        step();
        chk("b2b done_single", {31'd0, o_done}, 32'd0);

        // Reset in the middle of a long op aborts it with no DONE.
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_base  = 16'd3;
        i_exp   = 7'd127;
        step();
        i_start = 1'b0;
        step();
        step();
        chk("abort busy_before", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        #2;
        chk("abort busy", {31'd0, o_busy}, 32'd0);
        chk("abort out", {16'd0, o_out}, 32'd0);
        chk("abort ovf", {31'd0, o_ovf}, 32'd0);
        chk("abort done", {31'd0, o_done}, 32'd0);
        step();
        i_rst = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_done || o_busy) busy_cnt++;
        end
        chk("abort no_done", busy_cnt, 32'd0);

        // Unit is fully usable after the abort.
        run_op("post_rst_3^5", 1'b1, 16'd3, 7'd5, 16'd243, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pow_seq
